// File: rtl/packetcheck_64.sv
// packetcheck_64: receive-side flow classifier and frame checker.
// Optional stat_clear port when PACKETCHECK_STAT_CLEAR_EN is defined.
module packetcheck_64 #(
  parameter int N_FLOWS = 4,
  parameter logic [N_FLOWS*11-1:0] SIZES = {4{11'd192}},
  parameter logic [N_FLOWS*48-1:0] D_MACS = {
    48'hABCDEF000001, 48'hABCDEF000002,
    48'hABCDEF000003, 48'hABCDEF000004},
  parameter logic [N_FLOWS*48-1:0] S_MACS = {
    48'hBEEFBEEF0001, 48'hBEEFBEEF0002,
    48'hBEEFBEEF0003, 48'hBEEFBEEF0004},
  parameter logic [N_FLOWS*16-1:0] ETHERTYPES = {4{16'h0800}},
  parameter logic [N_FLOWS*8-1:0] PAYLOADS = {
    8'hAA, 8'hBB, 8'hCC, 8'hDD},
  localparam int FW = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef PACKETCHECK_STAT_CLEAR_EN
  input  logic                 stat_clear,
`endif
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 pkt_done,
  output logic [FW-1:0]        pkt_flow,
  output logic                 pkt_ok,
  output logic [N_FLOWS*32-1:0] rx_pkt_count,
  output logic [N_FLOWS*32-1:0] rx_err_count,
  output logic [31:0]          unmatched_count,
  output logic [31:0]          runt_count
);

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    DROP
  } state_t;

  state_t             state;
  logic [N_FLOWS-1:0] part_q;
  logic [FW-1:0]      flow_q;
  logic               err_q;
  logic [15:0]        cnt_q;

  logic [31:0] pkt_cnt [N_FLOWS];
  logic [31:0] err_cnt [N_FLOWS];
  logic [31:0] unm_cnt;
  logic [31:0] runt_cnt;

  logic               acc;
  logic [7:0]         b [8];
  logic [N_FLOWS-1:0] d_hit;
  logic [N_FLOWS-1:0] h1_hit;
  logic [N_FLOWS-1:0] mvec;
  logic [FW-1:0]      hit_idx;
  logic [FW-1:0]      pay_flow;
  logic [7:0]         pay_byte;
  logic [10:0]        size_exp;
  logic               pay_bad;
  logic               keep_bad;
  logic               len_bad;
  logic [3:0]         pop;
  logic [15:0]        base;
  logic [16:0]        sum;
  logic [15:0]        cnt_sum;
  logic               ev_runt;
  logic               ev_unm;
  logic               ev_flow;
  logic               ev_ok;
  logic [FW-1:0]      ev_idx;

  assign acc = s_axis_tvalid && s_axis_tready;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign b[k] = s_axis_tdata[8*k +: 8];
  end

  // Per-flow header comparisons for beat 0 and beat 1 layouts
  always_comb begin
    d_hit  = '0;
    h1_hit = '0;
    for (int i = 0; i < N_FLOWS; i++) begin
      d_hit[i] =
        ({b[0], b[1], b[2], b[3], b[4], b[5]}
          == D_MACS[i*48 +: 48]) &&
        ({b[6], b[7]} == S_MACS[i*48+32 +: 16]);
      h1_hit[i] =
        ({b[0], b[1], b[2], b[3]}
          == S_MACS[i*48 +: 32]) &&
        ({b[4], b[5]} == ETHERTYPES[i*16 +: 16]);
    end
  end

  assign mvec = part_q & h1_hit;

  // Lowest matching flow index wins
  always_comb begin
    hit_idx = '0;
    for (int i = N_FLOWS - 1; i >= 0; i--) begin
      if (mvec[i]) hit_idx = FW'(i);
    end
  end

  assign pay_flow = (state == HDR1) ? hit_idx : flow_q;

  // Look up the fill byte and length of the active flow
  always_comb begin
    pay_byte = PAYLOADS[7:0];
    size_exp = SIZES[10:0];
    for (int i = 0; i < N_FLOWS; i++) begin
      if (pay_flow == FW'(i)) begin
        pay_byte = PAYLOADS[i*8 +: 8];
        size_exp = SIZES[i*11 +: 11];
      end
    end
  end

  // Per-beat payload, tkeep and length checks
  always_comb begin
    pop     = '0;
    pay_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pop = pop + {3'b0, s_axis_tkeep[k]};
      if (s_axis_tkeep[k] && (b[k] != pay_byte) &&
          ((state == PAYLOAD) ||
           ((state == HDR1) && (k >= 6))))
        pay_bad = 1'b1;
    end
    if (s_axis_tlast)
      keep_bad = (s_axis_tkeep &
                  (s_axis_tkeep + 8'd1)) != 8'd0;
    else
      keep_bad = s_axis_tkeep != 8'hFF;
    base    = (state == HDR0) ? 16'd0 : cnt_q;
    sum     = {1'b0, base} + {13'b0, pop};
    cnt_sum = sum[16] ? 16'hFFFF : sum[15:0];
    len_bad = cnt_sum != {5'b0, size_exp};
  end

  // Frame completion events on the accepted tlast beat
  always_comb begin
    ev_runt = 1'b0;
    ev_unm  = 1'b0;
    ev_flow = 1'b0;
    ev_ok   = 1'b0;
    ev_idx  = '0;
    if (acc && s_axis_tlast) begin
      case (state)
        HDR0: ev_runt = 1'b1;
        HDR1: begin
          if (s_axis_tkeep[5:0] != 6'h3F) begin
            ev_runt = 1'b1;
          end else if (|mvec) begin
            ev_flow = 1'b1;
            ev_idx  = hit_idx;
            ev_ok   = !(err_q | keep_bad |
                        pay_bad | len_bad);
          end else begin
            ev_unm = 1'b1;
          end
        end
        PAYLOAD: begin
          ev_flow = 1'b1;
          ev_idx  = flow_q;
          ev_ok   = !(err_q | keep_bad |
                      pay_bad | len_bad);
        end
        DROP: ev_unm = 1'b1;
        default: ev_unm = 1'b0;
      endcase
    end
  end

  // Frame parser FSM with registered ready and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HDR0;
      part_q        <= '0;
      flow_q        <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      s_axis_tready <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_flow      <= '0;
      pkt_ok        <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      pkt_done      <= ev_runt | ev_unm | ev_flow;
      if (ev_runt | ev_unm | ev_flow) begin
        pkt_flow <= ev_idx;
        pkt_ok   <= ev_ok;
      end
      if (acc) begin
        case (state)
          HDR0: begin
            part_q <= d_hit;
            cnt_q  <= cnt_sum;
            err_q  <= !s_axis_tlast &&
                      (s_axis_tkeep != 8'hFF);
            state  <= s_axis_tlast ? HDR0 : HDR1;
          end
          HDR1: begin
            cnt_q  <= cnt_sum;
            flow_q <= hit_idx;
            err_q  <= err_q | keep_bad | pay_bad;
            if (s_axis_tlast)
              state <= HDR0;
            else if (|mvec)
              state <= PAYLOAD;
            else
              state <= DROP;
          end
          PAYLOAD: begin
            cnt_q <= cnt_sum;
            err_q <= err_q | keep_bad | pay_bad;
            if (s_axis_tlast) state <= HDR0;
          end
          DROP: begin
            if (s_axis_tlast) state <= HDR0;
          end
          default: state <= HDR0;
        endcase
      end
    end
  end

  // Statistics counters, wrapping modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FLOWS; i++) begin
        pkt_cnt[i] <= '0;
        err_cnt[i] <= '0;
      end
      unm_cnt  <= '0;
      runt_cnt <= '0;
`ifdef PACKETCHECK_STAT_CLEAR_EN
    end else if (stat_clear) begin
      for (int i = 0; i < N_FLOWS; i++) begin
        pkt_cnt[i] <= '0;
        err_cnt[i] <= '0;
      end
      unm_cnt  <= '0;
      runt_cnt <= '0;
`endif
    end else begin
      for (int i = 0; i < N_FLOWS; i++) begin
        if (ev_flow && (ev_idx == FW'(i))) begin
          pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
          if (!ev_ok)
            err_cnt[i] <= err_cnt[i] + 32'd1;
        end
      end
      if (ev_unm)  unm_cnt  <= unm_cnt + 32'd1;
      if (ev_runt) runt_cnt <= runt_cnt + 32'd1;
    end
  end

  for (genvar i = 0; i < N_FLOWS; i++) begin : g_cnt
    assign rx_pkt_count[i*32 +: 32] = pkt_cnt[i];
    assign rx_err_count[i*32 +: 32] = err_cnt[i];
  end

  assign unmatched_count = unm_cnt;
  assign runt_count      = runt_cnt;

endmodule
